// File: rtl/reflet_bus_arbiter_pkg.sv
// Shared definitions for the Reflet two-master bus arbiter: state encoding,
// master indices and the owner-to-state helper.
package reflet_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_OWN0 = 2'd1,
    ARB_OWN1 = 2'd2
  } arb_state_t;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  function automatic arb_state_t owner_state(input logic master);
    return master ? ARB_OWN1 : ARB_OWN0;
  endfunction

endpackage

// File: rtl/reflet_bus_arbiter_if.sv
// Bus bundle between the two masters, the arbiter and the peripheral block.
// The master modport is the driving side (masters plus peripheral read data).
interface reflet_bus_arbiter_if #(
  parameter int wordsize  = 16,
  parameter int addr_size = 16
);
  // Handshake: reqN is held high with a stable addrN/wdataN/weN until the
  // cycle in which gntN is seen high; that cycle is the transfer. If gntN
  // falls while reqN is still high the master keeps its transaction pending.
  logic                 req0;
  logic [addr_size-1:0] addr0;
  logic [wordsize-1:0]  wdata0;
  logic                 we0;
  logic                 gnt0;
  logic [wordsize-1:0]  rdata0;

  logic                 req1;
  logic [addr_size-1:0] addr1;
  logic [wordsize-1:0]  wdata1;
  logic                 we1;
  logic                 gnt1;
  logic [wordsize-1:0]  rdata1;

  logic                 bus_enable;
  logic [addr_size-1:0] bus_addr;
  logic [wordsize-1:0]  bus_wdata;
  logic                 bus_we;
  logic [wordsize-1:0]  bus_rdata;
  logic                 abort;

  modport master (
    output req0, addr0, wdata0, we0,
    output req1, addr1, wdata1, we1,
    output bus_rdata,
    input  gnt0, rdata0, gnt1, rdata1,
    input  bus_enable, bus_addr, bus_wdata, bus_we, abort
  );

  modport slave (
    input  req0, addr0, wdata0, we0,
    input  req1, addr1, wdata1, we1,
    input  bus_rdata,
    output gnt0, rdata0, gnt1, rdata1,
    output bus_enable, bus_addr, bus_wdata, bus_we, abort
  );
endinterface

// File: rtl/reflet_bus_arbiter_hold_counter.sv
// Saturating up-counter with synchronous clear, count enable and a flag
// raised while the count equals the terminal value.
module reflet_arb_hold_counter #(
  parameter int unsigned term_val = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic term_o
);
  localparam int unsigned CW = (term_val < 1) ? 1 : $clog2(term_val + 1);
  localparam logic [CW-1:0] TERM = CW'(term_val);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != TERM)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign term_o = (cnt_q == TERM);

endmodule

// File: rtl/reflet_bus_arbiter.sv
// Two-master round-robin arbiter for the Reflet peripheral bus with bounded
// hold under contention. Optional absolute hold limit: REFLET_ARB_TIMEOUT_EN.
module reflet_bus_arbiter
  import reflet_arb_pkg::*;
#(
  parameter int wordsize       = 16,
  parameter int addr_size      = 16,
  parameter int max_hold       = 8,
  parameter int timeout_cycles = 255
) (
  input  logic                clk,
  input  logic                reset,
  reflet_bus_arbiter_if.slave bus,
  output arb_state_t          dbg_state_o
);

  arb_state_t state_q, state_d;
  logic       last_owner_q, last_owner_d;
  logic       gnt0_q, gnt1_q;
  logic       eff_req0, eff_req1;
  logic       own_req, oth_req;
  arb_state_t oth_state;
  logic       grant_chg, stay_owned;
  logic       hold_en, hold_term;

`ifdef REFLET_ARB_TIMEOUT_EN
  logic block0_q, block1_q;
  logic abort_q, force_rel, to_term;

  // A master released by timeout is ignored until it drops its request once.
  assign eff_req0 = bus.req0 & ~block0_q;
  assign eff_req1 = bus.req1 & ~block1_q;
`else
  assign eff_req0 = bus.req0;
  assign eff_req1 = bus.req1;
`endif

  assign own_req   = (state_q == ARB_OWN1) ? eff_req1 : eff_req0;
  assign oth_req   = (state_q == ARB_OWN1) ? eff_req0 : eff_req1;
  assign oth_state = (state_q == ARB_OWN1) ? ARB_OWN0 : ARB_OWN1;

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    hold_en      = 1'b0;
`ifdef REFLET_ARB_TIMEOUT_EN
    force_rel    = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (eff_req0 && eff_req1) state_d = owner_state(~last_owner_q);
        else if (eff_req0)        state_d = ARB_OWN0;
        else if (eff_req1)        state_d = ARB_OWN1;
      end
      ARB_OWN0, ARB_OWN1: begin
        if (!own_req) begin
          state_d = oth_req ? oth_state : ARB_IDLE;
        end
`ifdef REFLET_ARB_TIMEOUT_EN
        else if (to_term) begin
          force_rel = 1'b1;
          state_d   = oth_req ? oth_state : ARB_IDLE;
        end
`endif
        else if (oth_req && hold_term) begin
          state_d = oth_state;
        end else begin
          hold_en = oth_req;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    if (state_d != state_q) begin
      if (state_d == ARB_OWN0) last_owner_d = MASTER0;
      if (state_d == ARB_OWN1) last_owner_d = MASTER1;
    end
  end

  assign grant_chg  = (state_d != state_q);
  assign stay_owned = (state_d == state_q) && (state_q != ARB_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ARB_IDLE;
      last_owner_q <= MASTER1;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
`ifdef REFLET_ARB_TIMEOUT_EN
      abort_q      <= 1'b0;
      block0_q     <= 1'b0;
      block1_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      gnt0_q       <= (state_d == ARB_OWN0);
      gnt1_q       <= (state_d == ARB_OWN1);
`ifdef REFLET_ARB_TIMEOUT_EN
      abort_q      <= force_rel;
      block0_q     <= (force_rel && state_q == ARB_OWN0) ? 1'b1 : (bus.req0 & block0_q);
      block1_q     <= (force_rel && state_q == ARB_OWN1) ? 1'b1 : (bus.req1 & block1_q);
`endif
    end
  end

  reflet_arb_hold_counter #(.term_val(max_hold - 1)) u_hold (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (grant_chg),
    .en_i   (hold_en),
    .term_o (hold_term)
  );

`ifdef REFLET_ARB_TIMEOUT_EN
  reflet_arb_hold_counter #(.term_val(timeout_cycles - 1)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (grant_chg),
    .en_i   (stay_owned),
    .term_o (to_term)
  );
  assign bus.abort = abort_q;
`else
  assign bus.abort = 1'b0;
`endif

  // Bus outputs depend only on registered grants, so an async reset idles them at once.
  logic [addr_size-1:0] addr_mux;
  logic [wordsize-1:0]  wdata_mux;

  assign addr_mux  = gnt0_q ? bus.addr0  : (gnt1_q ? bus.addr1  : '0);
  assign wdata_mux = gnt0_q ? bus.wdata0 : (gnt1_q ? bus.wdata1 : '0);

  assign bus.gnt0       = gnt0_q;
  assign bus.gnt1       = gnt1_q;
  assign bus.bus_enable = gnt0_q | gnt1_q;
  assign bus.bus_addr   = addr_mux;
  assign bus.bus_wdata  = wdata_mux;
  assign bus.bus_we     = (gnt0_q & bus.we0) | (gnt1_q & bus.we1);
  assign bus.rdata0     = gnt0_q ? bus.bus_rdata : '0;
  assign bus.rdata1     = gnt1_q ? bus.bus_rdata : '0;
  assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_reflet_bus_arbiter.sv
// Self-checking bench for reflet_bus_arbiter: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
module tb_reflet_bus_arbiter;

  localparam int MH = 8;
`ifdef REFLET_ARB_TIMEOUT_EN
  localparam bit TO_EN  = 1'b1;
  localparam int TO_CYC = 16;
  localparam int ALONE  = 4;
`else
  localparam bit TO_EN  = 1'b0;
  localparam int TO_CYC = 255;
  localparam int ALONE  = 50;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] dbg_state;
  bit         cmp_en = 1'b0;
  int         n_checks = 0;
  int         n_fail = 0;

  reflet_bus_arbiter_if #(.wordsize(16), .addr_size(16)) bus_if ();

  reflet_bus_arbiter #(
    .wordsize(16), .addr_size(16), .max_hold(MH), .timeout_cycles(TO_CYC)
  ) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus_if.slave),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_owner = -1;
  int m_last  = 1;
  int m_hold  = 0;
  int m_tcnt  = 0;
  bit m_blk[2];
  bit m_abort = 1'b0;

  function automatic void model_step();
    bit raw[2];
    bit r[2];
    int nxt;
    int o;
    int p;
    raw[0] = bus_if.req0;
    raw[1] = bus_if.req1;
    r[0] = raw[0] && !m_blk[0];
    r[1] = raw[1] && !m_blk[1];
    m_abort = 1'b0;
    if (m_owner < 0) begin
      if (r[0] && r[1]) nxt = 1 - m_last;
      else if (r[0])    nxt = 0;
      else if (r[1])    nxt = 1;
      else              nxt = -1;
    end else begin
      o = m_owner;
      p = 1 - o;
      if (!r[o]) nxt = r[p] ? p : -1;
      else if (TO_EN && m_tcnt == TO_CYC - 1) begin
        nxt = r[p] ? p : -1;
        m_abort = 1'b1;
      end else if (r[p] && m_hold == MH - 1) nxt = p;
      else begin
        nxt = o;
        if (r[p] && m_hold < MH - 1) m_hold++;
        if (m_tcnt < TO_CYC - 1) m_tcnt++;
      end
    end
    for (int m = 0; m < 2; m++) if (!raw[m]) m_blk[m] = 1'b0;
    if (m_abort) m_blk[m_owner] = 1'b1;
    if (nxt != m_owner) begin
      m_hold = 0;
      m_tcnt = 0;
      if (nxt >= 0) m_last = nxt;
    end
    m_owner = nxt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_hold = 0; m_tcnt = 0;
      m_blk[0] = 1'b0; m_blk[1] = 1'b0; m_abort = 1'b0;
    end else begin
      model_step();
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [15:0] e_addr, e_wdata;
    logic        e_we;
    if (cmp_en) begin
      e_addr  = (m_owner == 0) ? bus_if.addr0  : (m_owner == 1) ? bus_if.addr1  : 16'h0;
      e_wdata = (m_owner == 0) ? bus_if.wdata0 : (m_owner == 1) ? bus_if.wdata1 : 16'h0;
      e_we    = (m_owner == 0) ? bus_if.we0    : (m_owner == 1) ? bus_if.we1    : 1'b0;
      check("m_gnt0",   32'(bus_if.gnt0),       32'(m_owner == 0));
      check("m_gnt1",   32'(bus_if.gnt1),       32'(m_owner == 1));
      check("m_enable", 32'(bus_if.bus_enable), 32'(m_owner >= 0));
      check("m_addr",   32'(bus_if.bus_addr),   32'(e_addr));
      check("m_wdata",  32'(bus_if.bus_wdata),  32'(e_wdata));
      check("m_we",     32'(bus_if.bus_we),     32'(e_we));
      check("m_rdata0", 32'(bus_if.rdata0),     (m_owner == 0) ? 32'(bus_if.bus_rdata) : 32'h0);
      check("m_rdata1", 32'(bus_if.rdata1),     (m_owner == 1) ? 32'(bus_if.bus_rdata) : 32'h0);
      check("m_abort",  32'(bus_if.abort),      32'(m_abort));
      check("m_state",  32'(dbg_state),         (m_owner < 0) ? 32'd0 : 32'(m_owner + 1));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus_if.req0 = 1'b0; bus_if.addr0 = '0; bus_if.wdata0 = '0; bus_if.we0 = 1'b0;
    bus_if.req1 = 1'b0; bus_if.addr1 = '0; bus_if.wdata1 = '0; bus_if.we1 = 1'b0;
    bus_if.bus_rdata = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    clear_inputs();
    #2;
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_inputs();
    repeat (2) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Reset state
    check("rst_gnt0",   32'(bus_if.gnt0),       32'h0);
    check("rst_gnt1",   32'(bus_if.gnt1),       32'h0);
    check("rst_enable", 32'(bus_if.bus_enable), 32'h0);
    check("rst_abort",  32'(bus_if.abort),      32'h0);
    check("rst_state",  32'(dbg_state),         32'h0);

    // Single request from master 0, one-cycle grant latency
    bus_if.req0 = 1'b1; bus_if.addr0 = 16'hFF04; bus_if.we0 = 1'b1; bus_if.wdata0 = 16'h00AA;
    tick();
    check("t1_gnt0",  32'(bus_if.gnt0),      32'h1);
    check("t1_addr",  32'(bus_if.bus_addr),  32'hFF04);
    check("t1_we",    32'(bus_if.bus_we),    32'h1);
    check("t1_wdata", 32'(bus_if.bus_wdata), 32'h00AA);
    check("t1_gnt1",  32'(bus_if.gnt1),      32'h0);

    // First tie goes to master 0, second tie to master 1
    do_reset();
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
    tick();
    check("t2_tie0", 32'(bus_if.gnt0), 32'h1);
    bus_if.req0 = 1'b0; bus_if.req1 = 1'b0;
    tick();
    check("t2_idle", 32'(bus_if.bus_enable), 32'h0);
    bus_if.req0 = 1'b1; bus_if.req1 = 1'b1;
    tick();
    check("t2_tie1", 32'(bus_if.gnt1), 32'h1);

    // Continuous contention: alternate every MH cycles, no idle gap
    for (int k = 0; k < 4; k++) begin
      repeat (MH - 1) begin
        tick();
        check("t3_keep", 32'(bus_if.gnt1 ^ k[0]), 32'h1);
        check("t3_busy", 32'(bus_if.bus_enable), 32'h1);
      end
      tick();
      check("t3_swap", 32'(bus_if.gnt0 ^ k[0]), 32'h1);
    end

    // Uncontended hold does not count toward preemption
    do_reset();
    bus_if.req1 = 1'b1;
    tick();
    repeat (ALONE) tick();
    check("t4_alone", 32'(bus_if.gnt1), 32'h1);
    bus_if.req0 = 1'b1;
    repeat (MH - 1) begin
      tick();
      check("t4_wait", 32'(bus_if.gnt1), 32'h1);
    end
    tick();
    check("t4_pre", 32'(bus_if.gnt0), 32'h1);

    // Read data routing, then async reset mid-write
    do_reset();
    bus_if.req1 = 1'b1; bus_if.we1 = 1'b1; bus_if.addr1 = 16'h0010;
    bus_if.wdata1 = 16'hBEEF; bus_if.bus_rdata = 16'h1234;
    tick();
    check("t5_rdata1", 32'(bus_if.rdata1), 32'h1234);
    check("t5_rdata0", 32'(bus_if.rdata0), 32'h0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_gnt1", 32'(bus_if.gnt1),   32'h0);
    check("t5_rst_we",   32'(bus_if.bus_we), 32'h0);
    #1 rst_n = 1'b1;

`ifdef REFLET_ARB_TIMEOUT_EN
    // Forced release after TO_CYC granted cycles, then blocked until req drops
    do_reset();
    bus_if.req0 = 1'b1;
    tick();
    check("t6_gnt", 32'(bus_if.gnt0), 32'h1);
    repeat (TO_CYC - 1) begin
      tick();
      check("t6_hold",  32'(bus_if.gnt0),  32'h1);
      check("t6_noabt", 32'(bus_if.abort), 32'h0);
    end
    tick();
    check("t6_abort", 32'(bus_if.abort), 32'h1);
    check("t6_drop",  32'(bus_if.gnt0),  32'h0);
    tick();
    check("t6_pulse", 32'(bus_if.abort), 32'h0);
    check("t6_block", 32'(bus_if.gnt0),  32'h0);
    bus_if.req0 = 1'b0;
    tick();
    bus_if.req0 = 1'b1;
    tick();
    check("t6_regnt", 32'(bus_if.gnt0), 32'h1);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) bus_if.req0 = ~bus_if.req0;
      if ($urandom_range(0, 7) == 0) bus_if.req1 = ~bus_if.req1;
      bus_if.addr0     = 16'($urandom);
      bus_if.addr1     = 16'($urandom);
      bus_if.wdata0    = 16'($urandom);
      bus_if.wdata1    = 16'($urandom);
      bus_if.we0       = 1'($urandom_range(0, 1));
      bus_if.we1       = 1'($urandom_range(0, 1));
      bus_if.bus_rdata = 16'($urandom);
      if (c == 1500) begin
        do_reset();
      end
      tick();
    end

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
